// File: rtl/nco_lut_gen.sv
// Purpose: phase-accumulator NCO emitting registered cosine (I) and sine (Q) samples from a cosine LUT.
// Latency: one clock from an enabled edge to i_out/q_out/out_valid; one sample per clock sustained.
// Backpressure: none; the consumer must take every sample flagged by out_valid.
//
// Ports:
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   en, clr             advance/emit this cycle; synchronous accumulator clear (clr wins over en)
//   cfg_load            capture freq_word into the step register and phase_off into the offset register
//   freq_word, phase_off
//                       phase step per enabled cycle; phase offset added before LUT addressing
//   i_out, q_out        offset-binary cosine / sine samples
//   out_valid           i_out/q_out were updated by the last edge
//   wrap                accumulator carried out on the step that produced the current sample
module nco_lut_gen #(
   parameter int DATA_W  = 8,
   parameter int ADDR_W  = 4,
   parameter int PHASE_W = 16,
   parameter int OFFSET  = 100,
   parameter int AMPL    = 71
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic               clr,
   input  logic               cfg_load,
   input  logic [PHASE_W-1:0] freq_word,
   input  logic [PHASE_W-1:0] phase_off,
   output logic [DATA_W-1:0]  i_out,
   output logic [DATA_W-1:0]  q_out,
   output logic               out_valid,
   output logic               wrap
);

   localparam int  DEPTH = 1 << ADDR_W;
   localparam real PI    = 3.14159265358979323846;

   // Default step advances exactly one LUT entry per enabled cycle.
   localparam logic [PHASE_W-1:0] FW_RST = PHASE_W'(1) << (PHASE_W - ADDR_W);

   // Quarter-turn in LUT entries: sin(theta) = cos(theta - pi/2).
   localparam logic [ADDR_W-1:0] QUARTER = ADDR_W'(DEPTH / 4);

   // Round-to-nearest cosine entry; all entries are positive so +0.5 then truncate rounds correctly.
   function automatic logic [DATA_W-1:0] lut_entry(input int k);
      real v;
      v = real'(OFFSET) + real'(AMPL) * $cos(2.0 * PI * real'(k) / real'(DEPTH));
      return DATA_W'($rtoi(v + 0.5));
   endfunction

   logic [DATA_W-1:0] lut [DEPTH];

   for (genvar k = 0; k < DEPTH; k++) begin : g_lut
      assign lut[k] = lut_entry(k);
   end

   logic [PHASE_W-1:0] acc;
   logic [PHASE_W-1:0] fw_reg;
   logic [PHASE_W-1:0] off_reg;

   logic [PHASE_W:0]   acc_sum;
   logic [ADDR_W-1:0]  addr;
   logic [ADDR_W-1:0]  q_addr;

   // Extra MSB of the sum is the accumulator carry that drives wrap.
   assign acc_sum = {1'b0, acc} + {1'b0, fw_reg};

   // Top ADDR_W bits of (acc + off_reg), taken modulo 2^PHASE_W.
   assign addr    = ADDR_W'((acc + off_reg) >> (PHASE_W - ADDR_W));
   assign q_addr  = addr - QUARTER;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc       <= '0;
         fw_reg    <= FW_RST;
         off_reg   <= '0;
         i_out     <= '0;
         q_out     <= '0;
         out_valid <= 1'b0;
         wrap      <= 1'b0;
      end else begin
         // New configuration takes effect from the next cycle; this cycle's
         // sample and step still use the old registers.
         if (cfg_load) begin
            fw_reg  <= freq_word;
            off_reg <= phase_off;
         end

         if (clr) begin
            acc       <= '0;
            out_valid <= 1'b0;
            wrap      <= 1'b0;
         end else if (en) begin
            i_out     <= lut[addr];
            q_out     <= lut[q_addr];
            acc       <= acc_sum[PHASE_W-1:0];
            out_valid <= 1'b1;
            wrap      <= acc_sum[PHASE_W];
         end else begin
            out_valid <= 1'b0;
            wrap      <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_nco_lut_gen.sv
// Directed bench for nco_lut_gen with default parameters (DEPTH = 16).
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
module tb_nco_lut_gen;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic        clr;
   logic        cfg_load;
   logic [15:0] freq_word;
   logic [15:0] phase_off;
   logic [7:0]  i_out;
   logic [7:0]  q_out;
   logic        out_valid;
   logic        wrap;

   int passed = 0;
   int total  = 0;

   // Hand-computed round(100 + 71*cos(2*pi*k/16)).
   logic [7:0] lut_e [16] = '{8'd171, 8'd166, 8'd150, 8'd127, 8'd100, 8'd73, 8'd50, 8'd34,
                              8'd29,  8'd34,  8'd50,  8'd73,  8'd100, 8'd127, 8'd150, 8'd166};

   always #5 clk = ~clk;

   nco_lut_gen dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .clr       (clr),
      .cfg_load  (cfg_load),
      .freq_word (freq_word),
      .phase_off (phase_off),
      .i_out     (i_out),
      .q_out     (q_out),
      .out_valid (out_valid),
      .wrap      (wrap)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      en = 1'b0; clr = 1'b0; cfg_load = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; idle_inputs(); freq_word = '0; phase_off = '0;
      tick(); tick();
      total++;
      if ({i_out, q_out, out_valid, wrap} !== 18'd0) begin
         $display("FAIL reset_state: got i=%0d q=%0d v=%0b w=%0b, want all 0", i_out, q_out, out_valid, wrap);
      end else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_default_sweep();
      int wraps;
      wraps = 0;
      en = 1'b1;
      for (int k = 0; k < 17; k++) begin
         tick();
         if (wrap === 1'b1) wraps++;
         total++;
         if (out_valid !== 1'b1 || i_out !== lut_e[k % 16] || q_out !== lut_e[(k + 12) % 16]) begin
            $display("FAIL sweep[%0d]: got i=%0d q=%0d v=%0b, want i=%0d q=%0d v=1",
                     k, i_out, q_out, out_valid, lut_e[k % 16], lut_e[(k + 12) % 16]);
         end else passed++;
         total++;
         if (wrap !== (k == 15)) begin
            $display("FAIL sweep_wrap[%0d]: got %0b, want %0b", k, wrap, (k == 15));
         end else passed++;
      end
      total++;
      if (wraps != 1) begin
         $display("FAIL sweep_wrap_count: got %0d, want 1", wraps);
      end else passed++;
      idle_inputs();
   endtask

   task automatic test_freq_step2();
      cfg_load = 1'b1; clr = 1'b1; freq_word = 16'h2000; phase_off = 16'h0000;
      tick();
      idle_inputs();
      en = 1'b1;
      for (int k = 0; k < 16; k++) begin
         tick();
         total++;
         if (out_valid !== 1'b1 || i_out !== lut_e[(2 * k) % 16] || wrap !== (k % 8 == 7)) begin
            $display("FAIL step2[%0d]: got i=%0d v=%0b w=%0b, want i=%0d v=1 w=%0b",
                     k, i_out, out_valid, wrap, lut_e[(2 * k) % 16], (k % 8 == 7));
         end else passed++;
      end
      idle_inputs();
   endtask

   task automatic test_phase_offset();
      cfg_load = 1'b1; clr = 1'b1; freq_word = 16'h1000; phase_off = 16'h4000;
      tick();
      idle_inputs();
      en = 1'b1;
      tick();
      total++;
      if (i_out !== 8'd100 || q_out !== 8'd171 || out_valid !== 1'b1) begin
         $display("FAIL phase_off: got i=%0d q=%0d v=%0b, want i=100 q=171 v=1", i_out, q_out, out_valid);
      end else passed++;
      // Back to zero offset for the following scenarios.
      idle_inputs();
      cfg_load = 1'b1; clr = 1'b1; phase_off = 16'h0000;
      tick();
      idle_inputs();
   endtask

   task automatic test_en_gaps();
      logic [7:0] exp_i [4] = '{8'd171, 8'd171, 8'd171, 8'd166};
      logic [7:0] exp_q [4] = '{8'd100, 8'd100, 8'd100, 8'd127};
      logic       pat   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      for (int k = 0; k < 4; k++) begin
         en = pat[k];
         tick();
         total++;
         if (i_out !== exp_i[k] || q_out !== exp_q[k] || out_valid !== pat[k] || wrap !== 1'b0) begin
            $display("FAIL en_gap[%0d]: got i=%0d q=%0d v=%0b w=%0b, want i=%0d q=%0d v=%0b w=0",
                     k, i_out, q_out, out_valid, wrap, exp_i[k], exp_q[k], pat[k]);
         end else passed++;
      end
      idle_inputs();
   endtask

   task automatic test_clr_and_cfg();
      clr = 1'b1;
      tick();
      idle_inputs();
      en = 1'b1;
      tick(); tick(); tick();
      total++;
      if (i_out !== 8'd150) begin
         $display("FAIL clr_pre: got i=%0d, want 150", i_out);
      end else passed++;
      clr = 1'b1;
      tick();
      total++;
      if (out_valid !== 1'b0 || i_out !== 8'd150) begin
         $display("FAIL clr_with_en: got v=%0b i=%0d, want v=0 i=150", out_valid, i_out);
      end else passed++;
      clr = 1'b0;
      tick();
      total++;
      if (i_out !== 8'd171 || out_valid !== 1'b1) begin
         $display("FAIL clr_restart: got i=%0d v=%0b, want i=171 v=1", i_out, out_valid);
      end else passed++;
      // acc = 0x1000; step change lands after this sample.
      cfg_load = 1'b1; freq_word = 16'h2000;
      tick();
      cfg_load = 1'b0;
      total++;
      if (i_out !== 8'd166) begin
         $display("FAIL cfg_same_cycle: got i=%0d, want 166", i_out);
      end else passed++;
      tick();
      total++;
      if (i_out !== 8'd150) begin
         $display("FAIL cfg_next1: got i=%0d, want 150", i_out);
      end else passed++;
      tick();
      total++;
      if (i_out !== 8'd100) begin
         $display("FAIL cfg_next2: got i=%0d, want 100", i_out);
      end else passed++;
   endtask

   task automatic test_async_reset();
      en = 1'b1;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (i_out !== 8'd0 || q_out !== 8'd0 || out_valid !== 1'b0 || wrap !== 1'b0) begin
         $display("FAIL async_reset: got i=%0d q=%0d v=%0b w=%0b, want 0 0 0 0", i_out, q_out, out_valid, wrap);
      end else passed++;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      total++;
      if (i_out !== 8'd171 || q_out !== 8'd100 || out_valid !== 1'b1) begin
         $display("FAIL post_reset0: got i=%0d q=%0d v=%0b, want 171 100 1", i_out, q_out, out_valid);
      end else passed++;
      tick();
      total++;
      if (i_out !== 8'd166) begin
         $display("FAIL post_reset_step: got i=%0d, want 166", i_out);
      end else passed++;
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_default_sweep();
      test_freq_step2();
      test_phase_offset();
      test_en_gaps();
      test_clr_and_cfg();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
